// File: rtl/pe_pkg.sv
// Shared types and width derivation for the pe_m_pipe processing element.
package pe_pkg;

    typedef enum logic [1:0] {
        PE_GEMM = 2'b00,
        PE_DIV  = 2'b01,
        PE_EXP  = 2'b10,
        PE_LOG  = 2'b11
    } pe_mode_e;

    // Signed multiplier operand width: integer + fraction + sign.
    function automatic int op_bw_f(input int int_bw, input int fra_bw);
        return int_bw + fra_bw + 1;
    endfunction

endpackage

// File: rtl/pe_sat.sv
// Signed clamp from IN_W to OUT_W bits; ovf flags any value outside the OUT_W range.
module pe_sat #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  d,
    output logic signed [OUT_W-1:0] q,
    output logic                    ovf
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    always_comb begin
        ovf = 1'b0;
        q   = d[OUT_W-1:0];
        if (d > MAX_V) begin
            ovf = 1'b1;
            q   = MAX_V[OUT_W-1:0];
        end else if (d < MIN_V) begin
            ovf = 1'b1;
            q   = MIN_V[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pe_m_pipe.sv
// Systolic PE: registered operand forwarding, one multiply stage and one saturating
// accumulate stage. gemm uses weight*activation+o_i, the uno modes use mac_t*var+weight.
module pe_m_pipe
    import pe_pkg::*;
#(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 4,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic                     v_i,
    input  logic                     w_ld,
    input  logic signed [MUL_BW-1:0] wc_i,
    input  logic signed [MUL_BW-1:0] x_i,
    input  logic signed [MUL_BW-1:0] var_i,
    input  logic signed [ACC_BW-1:0] mac_i,
    input  logic signed [ACC_BW-1:0] o_i,
    input  logic                     clr,
    output logic signed [MUL_BW-1:0] x_o,
    output logic signed [MUL_BW-1:0] var_o,
    output logic signed [MUL_BW-1:0] wc_o,
    output logic                     v_x_o,
    output logic                     w_ld_o,
    output logic signed [ACC_BW-1:0] o_o,
    output logic signed [ACC_BW-1:0] mac_o,
    output logic                     v_o,
    output logic                     sat_o
);

    localparam int OP_BW = op_bw_f(INT_BW, FRA_BW);
    localparam int P_BW  = 2 * OP_BW;

    logic signed [MUL_BW-1:0] ireg, vreg, wreg;
    logic                     v1, v2;
    logic signed [P_BW-1:0]   p1;
    logic signed [ACC_BW-1:0] a1, oreg;
    logic signed [ACC_BW-1:0] mac_sh;
    logic signed [OP_BW-1:0]  mac_t, left_op, right_op;
    logic signed [ACC_BW:0]   sum;
    logic signed [ACC_BW-1:0] sum_sat;
    logic                     mac_ovf, sum_ovf, is_gemm, sat_evt;

    assign mac_sh = mac_i >>> FRA_BW;

    pe_sat #(.IN_W(ACC_BW), .OUT_W(OP_BW)) u_mac_sat (
        .d  (mac_sh),
        .q  (mac_t),
        .ovf(mac_ovf)
    );

    // Mode only steers stage 1; later stages carry no mode information.
    assign is_gemm = (pe_mode_e'(mode) == PE_GEMM);

    always_comb begin
        left_op  = mac_t;
        right_op = $signed(vreg[MUL_BW-1 -: OP_BW]);
        if (is_gemm) begin
            left_op  = $signed(wreg[OP_BW-1:0]);
            right_op = $signed(ireg[MUL_BW-1 -: OP_BW]);
        end
    end

    assign sum = (ACC_BW+1)'(p1) + (ACC_BW+1)'(a1);

    pe_sat #(.IN_W(ACC_BW+1), .OUT_W(ACC_BW)) u_acc_sat (
        .d  (sum),
        .q  (sum_sat),
        .ovf(sum_ovf)
    );

    // The mac clamp only matters when an uno operation actually consumes mac_t.
    assign sat_evt = (v1 && !is_gemm && mac_ovf) || (v2 && sum_ovf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ireg   <= '0;
            vreg   <= '0;
            v1     <= 1'b0;
            w_ld_o <= 1'b0;
        end else begin
            ireg   <= x_i;
            vreg   <= var_i;
            v1     <= v_i;
            w_ld_o <= w_ld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wreg <= '0;
        end else if (w_ld) begin
            wreg <= MUL_BW'($signed(wc_i[OP_BW-1:0]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= '0;
            a1 <= '0;
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                p1 <= P_BW'(left_op) * P_BW'(right_op);
                a1 <= is_gemm ? o_i : ACC_BW'(wreg);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg  <= '0;
            v_o   <= 1'b0;
            sat_o <= 1'b0;
        end else begin
            v_o   <= v2;
            sat_o <= sat_evt | (sat_o & ~clr);
            if (v2) begin
                oreg <= sum_sat;
            end
        end
    end

    assign x_o   = ireg;
    assign var_o = vreg;
    assign v_x_o = v1;
    assign wc_o  = wreg;
    assign o_o   = oreg;
    assign mac_o = oreg;

endmodule

// File: tb/tb_pe_m_pipe.sv
// Bench for pe_m_pipe: vector table, scoreboard-checked results and hand-built pipeline corner sequences.
module tb_pe_m_pipe;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         mode;
    logic               v_i, w_ld, clr;
    logic signed [15:0] wc_i, x_i, var_i;
    logic signed [31:0] mac_i, o_i;
    logic signed [15:0] x_o, var_o, wc_o;
    logic               v_x_o, w_ld_o, v_o, sat_o;
    logic signed [31:0] o_o, mac_o;

    int checks   = 0;
    int failures = 0;
    int got      = 0;
    int sent     = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e_v;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [15:0] w;
        logic [15:0] x;
        logic [15:0] vr;
        logic [31:0] mac;
        logic [31:0] o;
        logic [31:0] exp;
        logic        sat;
    } vec_t;

    vec_t vecs[8];

    pe_m_pipe #(.INT_BW(5), .FRA_BW(4), .MUL_BW(16), .ACC_BW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .v_i   (v_i),
        .w_ld  (w_ld),
        .wc_i  (wc_i),
        .x_i   (x_i),
        .var_i (var_i),
        .mac_i (mac_i),
        .o_i   (o_i),
        .clr   (clr),
        .x_o   (x_o),
        .var_o (var_o),
        .wc_o  (wc_o),
        .v_x_o (v_x_o),
        .w_ld_o(w_ld_o),
        .o_o   (o_o),
        .mac_o (mac_o),
        .v_o   (v_o),
        .sat_o (sat_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && v_o) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_v_o actual o_o=%0h required no valid", o_o);
            end else begin
                e_v = exp_q.pop_front();
                if (o_o !== e_v || mac_o !== e_v) begin
                    failures++;
                    $display("FAIL result actual o_o=%0h mac_o=%0h required=%0h", o_o, mac_o, e_v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [15:0] w);
        wc_i = w;
        w_ld = 1'b1;
        step();
        w_ld = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic wait_results(input int target, input string name);
        int n;
        n = 0;
        while (got < target && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_arrived"}, 32'(got >= target), 32'd1);
    endtask

    task automatic issue(input logic [1:0] m, input logic [15:0] x, input logic [15:0] vr,
                         input logic [31:0] mac, input logic [31:0] o, input logic [31:0] exp);
        x_i   = x;
        var_i = vr;
        v_i   = 1'b1;
        exp_q.push_back(exp);
        sent++;
        step();
        v_i   = 1'b0;
        mode  = m;
        mac_i = mac;
        o_i   = o;
        step();
    endtask

    function automatic logic [31:0] model_gemm(input longint w, input logic [15:0] x, input logic [31:0] o);
        longint xt, r;
        xt = longint'($signed(x)) >>> 6;
        r  = w * xt + longint'($signed(o));
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        return r[31:0];
    endfunction

    initial begin
        logic [15:0] xs[4];
        logic [31:0] os[4];
        logic        hist[10];
        logic [31:0] oh[10];
        logic [31:0] last_e;
        int          got0;

        vecs[0] = '{"gemm_basic",   2'b00, 16'h0003, 16'h0140, 16'h0000, 32'h0000_0000, 32'h0000_0007, 32'd22,         1'b0};
        vecs[1] = '{"div_mac_clamp",2'b01, 16'h0000, 16'h0000, 16'h0040, 32'h0000_4000, 32'h0000_1234, 32'd511,        1'b1};
        vecs[2] = '{"gemm_ovf",     2'b00, 16'h01FF, 16'h7FC0, 16'h0000, 32'h0000_0000, 32'h7FFF_FFF0, 32'h7FFF_FFFF,  1'b1};
        vecs[3] = '{"gemm_neg",     2'b00, 16'h03FE, 16'hFFC0, 16'h0000, 32'h7FFF_FFFF, 32'd100,       32'd102,        1'b0};
        vecs[4] = '{"exp_basic",    2'b10, 16'h0005, 16'h0000, 16'h0100, 32'h0000_0030, 32'h0000_1234, 32'd17,         1'b0};
        vecs[5] = '{"log_neg",      2'b11, 16'h03FF, 16'h0000, 16'hFF80, 32'hFFFF_FF00, 32'h0000_1234, 32'd31,         1'b0};
        vecs[6] = '{"div_neg_clamp",2'b01, 16'h0000, 16'h0000, 16'h0040, 32'h8000_0000, 32'h0000_1234, 32'hFFFF_FE00,  1'b1};
        vecs[7] = '{"gemm_udf",     2'b00, 16'h0200, 16'h7FC0, 16'h0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000,  1'b1};

        rst_n = 1'b0;
        mode  = 2'b00;
        v_i   = 1'b0;
        w_ld  = 1'b0;
        clr   = 1'b0;
        wc_i  = '0;
        x_i   = 16'h1234;
        var_i = 16'h4321;
        mac_i = '0;
        o_i   = '0;
        #12;
        chk("rst_o_o", o_o, 32'd0);
        chk("rst_v_o", 32'(v_o), 32'd0);
        chk("rst_sat_o", 32'(sat_o), 32'd0);
        chk("rst_x_o", 32'(x_o), 32'd0);
        chk("rst_v_x_o", 32'(v_x_o), 32'd0);
        #5;
        rst_n = 1'b1;
        x_i   = '0;
        var_i = '0;

        // first operation after reset: latency and forwarding
        step();
        load_w(16'h0003);
        chk("wc_o_load", 32'(wc_o), 32'd3);
        chk("w_ld_o_fwd", 32'(w_ld_o), 32'd1);
        x_i = 16'h0140;
        v_i = 1'b1;
        exp_q.push_back(32'd22);
        sent++;
        step();
        chk("x_o_fwd", 32'(x_o), 32'h0140);
        chk("v_x_o_fwd", 32'(v_x_o), 32'd1);
        v_i = 1'b0;
        o_i = 32'd7;
        step();
        @(negedge clk);
        chk("lat_not_early", 32'(v_o), 32'd0);
        step();
        @(negedge clk);
        chk("lat_v_o", 32'(v_o), 32'd1);
        chk("lat_o_o", o_o, 32'd22);
        wait_results(sent, "lat");

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            clr_pulse();
            load_w(vecs[i].w);
            issue(vecs[i].mode, vecs[i].x, vecs[i].vr, vecs[i].mac, vecs[i].o, vecs[i].exp);
            wait_results(sent, vecs[i].name);
            chk({vecs[i].name, "_sat"}, 32'(sat_o), 32'(vecs[i].sat));
            if (vecs[i].sat) begin
                clr_pulse();
                chk({vecs[i].name, "_clr"}, 32'(sat_o), 32'd0);
            end
        end

        // clr coincident with a saturation event keeps sat_o set
        clr_pulse();
        load_w(16'h0000);
        x_i   = '0;
        var_i = 16'h0040;
        v_i   = 1'b1;
        exp_q.push_back(32'd511);
        sent++;
        step();
        v_i   = 1'b0;
        mode  = 2'b01;
        mac_i = 32'h0000_4000;
        clr   = 1'b1;
        step();
        clr   = 1'b0;
        chk("clr_vs_sat", 32'(sat_o), 32'd1);
        wait_results(sent, "clr_vs_sat");

        // weight load on the stage-1 edge: in-flight op keeps the old weight
        load_w(16'h0003);
        mode  = 2'b00;
        x_i   = 16'h0140;
        v_i   = 1'b1;
        exp_q.push_back(32'd15);
        sent++;
        step();
        exp_q.push_back(32'd45);
        sent++;
        o_i   = '0;
        wc_i  = 16'h0009;
        w_ld  = 1'b1;
        step();
        w_ld  = 1'b0;
        v_i   = 1'b0;
        step();
        wait_results(sent, "wld_collide");
        chk("wc_o_after", 32'(wc_o), 32'd9);

        // back-to-back stream then idle
        load_w(16'h0007);
        mode = 2'b00;
        for (int k = 0; k < 4; k++) begin
            xs[k] = 16'($urandom_range(0, 65535));
            os[k] = 32'($urandom_range(0, 2000)) - 32'd1000;
        end
        for (int t = 0; t < 10; t++) begin
            v_i = (t < 4);
            if (t < 4) begin
                x_i = xs[t];
                exp_q.push_back(model_gemm(7, xs[t], os[t]));
                sent++;
            end
            o_i = (t >= 1 && t <= 4) ? os[t-1] : 32'd0;
            @(negedge clk);
            hist[t] = v_o;
            oh[t]   = o_o;
            step();
        end
        v_i = 1'b0;
        last_e = model_gemm(7, xs[3], os[3]);
        for (int t = 0; t < 10; t++) begin
            chk($sformatf("stream_v_o_%0d", t), 32'(hist[t]), 32'(t >= 3 && t <= 6));
        end
        for (int t = 7; t < 10; t++) begin
            chk($sformatf("stream_hold_%0d", t), oh[t], last_e);
        end
        wait_results(sent, "stream");

        // asynchronous reset with two operations in flight
        clr_pulse();
        load_w(16'h0000);
        x_i   = '0;
        var_i = 16'h0040;
        v_i   = 1'b1;
        step();
        mode  = 2'b01;
        mac_i = 32'h0000_4000;
        wc_i  = 16'h0005;
        w_ld  = 1'b1;
        step();
        chk("pre_rst_sat", 32'(sat_o), 32'd1);
        chk("pre_rst_wc", 32'(wc_o), 32'd5);
        rst_n = 1'b0;
        #1;
        v_i  = 1'b0;
        w_ld = 1'b0;
        chk("mid_rst_o_o", o_o, 32'd0);
        chk("mid_rst_mac_o", mac_o, 32'd0);
        chk("mid_rst_v_o", 32'(v_o), 32'd0);
        chk("mid_rst_sat_o", 32'(sat_o), 32'd0);
        chk("mid_rst_v_x_o", 32'(v_x_o), 32'd0);
        chk("mid_rst_w_ld_o", 32'(w_ld_o), 32'd0);
        chk("mid_rst_wc_o", 32'(wc_o), 32'd0);
        chk("mid_rst_var_o", 32'(var_o), 32'd0);
        got0 = got;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step();
        chk("no_pulse_after_rst", 32'(got), 32'(got0));

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_m_pipe.md
PE_M_PIPE -- requirements
Module: pe_m_pipe

Interface
REQ-001 Parameter INT_BW, default 5, integer bits of the fixed-point operand.
REQ-002 Parameter FRA_BW, default 4, fraction bits of the operand.
REQ-003 Parameter MUL_BW, default 16, streamed operand width; SHALL be at least INT_BW+FRA_BW+1.
REQ-004 Parameter ACC_BW, default 32, accumulator width; SHALL be at least 2*(INT_BW+FRA_BW+1).
REQ-005 Ports: clk in 1, clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 mode in 2, operation: 00 gemm, 01 div, 10 exp, 11 log; v_i in 1, valid aligned with x_i.
REQ-007 w_ld in 1, weight-load strobe; wc_i in MUL_BW signed, weight or coefficient; x_i in MUL_BW signed, activation.
REQ-008 var_i in MUL_BW signed, uno variable; mac_i in ACC_BW signed, uno left operand; o_i in ACC_BW signed, partial sum.
REQ-009 clr in 1, clears sat_o.
REQ-010 Outputs: x_o, var_o, wc_o MUL_BW signed; v_x_o 1; w_ld_o 1; o_o, mac_o ACC_BW signed; v_o 1; sat_o 1.

Function
REQ-011 OP_BW = INT_BW+FRA_BW+1 SHALL be the signed multiplier operand width.
REQ-012 Every edge: ireg<=x_i, vreg<=var_i, v1<=v_i, w_ld_o<=w_ld; outputs x_o=ireg, var_o=vreg, v_x_o=v1.
REQ-013 wreg SHALL load wc_i[OP_BW-1:0] sign-extended only when w_ld=1, else hold; wc_o = wreg.
REQ-014 mac_t SHALL be mac_i arithmetic-shifted right by FRA_BW, clamped to [-2^(OP_BW-1), 2^(OP_BW-1)-1]; a clamp is a saturation event.
REQ-015 Stage 1 (edge after ireg capture), when v1=1: left = wreg (gemm) or mac_t (uno); right = ireg[MUL_BW-1 -: OP_BW] (gemm) or vreg[MUL_BW-1 -: OP_BW] (uno).
REQ-016 Stage 1 SHALL register p1=left*right (2*OP_BW signed), a1 = o_i (gemm) or sign-extended wreg (uno), v2=v1.
REQ-017 Mode SHALL be sampled at stage 1 only; a mode change never affects operations already past stage 1.
REQ-018 Stage 2, when v2=1: oreg <= sign-extended p1 + a1, saturated to ACC_BW signed range; overflow is a saturation event.
REQ-019 oreg SHALL hold when v2=0; o_o=mac_o=oreg; v_o = registered v2.
REQ-020 Latency: x_i/v_i at edge k yields o_o/v_o at edge k+3; o_i and mac_i are sampled at edge k+1.
REQ-021 w_ld=1 coincident with stage-1 capture SHALL use the pre-edge wreg value.
REQ-022 sat_o SHALL set on any saturation event of a valid operation and stay set until clr=1.
REQ-023 clr and a saturation event on the same edge SHALL leave sat_o=1.
REQ-024 Back-to-back valids SHALL sustain one result per cycle, no bubbles.

Reset
REQ-025 rst_n=0 SHALL immediately clear ireg, vreg, wreg, p1, a1, oreg, v1, v2, v_o, w_ld_o and sat_o to 0, including mid-operation.
REQ-026 The first valid result after reset release SHALL appear exactly 3 edges after its v_i.

Structure
REQ-027 Shared package pe_pkg SHALL hold the mode enum typedef (PE_GEMM, PE_DIV, PE_EXP, PE_LOG) and the OP_BW derivation function.
REQ-028 A sub-module pe_sat (parametrised signed clamp with overflow flag) SHALL be used for REQ-014 and REQ-018.

Verification (INT_BW=5, FRA_BW=4, MUL_BW=16, ACC_BW=32, OP_BW=10)
REQ-029 gemm: w_ld=1, wc_i=3; next cycle x_i=0x0140, v_i=1; o_i=7 one cycle later -> o_o=22, v_o=1 three edges after x_i.
REQ-030 div: wreg=0, var_i=0x0040, mac_i=0x00004000 -> mac_t=511, o_o=511, sat_o=1; clr=1 -> sat_o=0.
REQ-031 gemm overflow: wreg=511, x_i=0x7FC0, o_i=0x7FFFFFF0 -> o_o=0x7FFFFFFF, sat_o=1.
REQ-032 Stream of 4 valids, then v_i=0 for 3 cycles -> o_o holds the 4th result, v_o=0 after the 4th result.
REQ-033 w_ld with wc_i=9 on the same edge as stage-1 capture of an operation using weight 3 -> that result uses 3, the next uses 9.
REQ-034 Assert rst_n=0 with 2 operations in flight -> all outputs 0 immediately, no v_o pulse after release.
